// File: rtl/fir_sample_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_sample_source                                                        |
// | Streams a host-loaded frame of samples from local RAM to the FIR input   |
// | under valid/ready, optionally looping, then pads with zero samples.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_sample_source #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int FLUSH_LEN = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_sample,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam int                   c_flush_w    = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [ADDR_W:0]      c_depth      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]      c_len_one    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]    c_idx_one    = ADDR_W'(1);
  localparam logic [c_flush_w-1:0] c_fcnt_one   = c_flush_w'(1);
  localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_q;
  logic [ADDR_W-1:0]    r_q_idx;
  logic [ADDR_W-1:0]    r_out_idx;
  logic [ADDR_W:0]      r_len;
  logic [c_flush_w-1:0] r_fcnt;

  logic              w_xfer;
  logic [ADDR_W:0]   w_len_m1;
  logic              w_out_last;
  logic              w_q_last;
  logic [ADDR_W-1:0] w_q_next;
  logic              w_load;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  // r_q always prefetches the sample that follows the one on the output,
  // wrapping to 0 after the last index so a looped frame has no bubble.
  assign w_xfer     = m_valid && m_ready;
  assign w_len_m1   = r_len - c_len_one;
  assign w_out_last = ({1'b0, r_out_idx} == w_len_m1);
  assign w_q_last   = ({1'b0, r_q_idx} == w_len_m1);
  assign w_q_next   = w_q_last ? '0 : r_q_idx + c_idx_one;
  assign w_load     = (r_state == S_STREAM) &&
                      (!m_valid || (w_xfer && (!w_out_last || loop_en)));
  assign w_rd_en    = (r_state == S_PRIME) || w_load;
  assign w_rd_addr  = (r_state == S_PRIME) ? '0 : w_q_next;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (w_rd_en) begin
      r_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      m_valid   <= 1'b0;
      m_sample  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
      r_len     <= '0;
      r_q_idx   <= '0;
      r_out_idx <= '0;
      r_fcnt    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        m_valid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if ((frame_len != '0) && (frame_len <= c_depth)) begin
                r_len   <= frame_len;
                r_state <= S_PRIME;
                busy    <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_PRIME: begin
            r_q_idx <= '0;
            r_state <= S_STREAM;
          end
          S_STREAM: begin
            if (w_load) begin
              m_valid   <= 1'b1;
              m_sample  <= r_q;
              r_out_idx <= r_q_idx;
              r_q_idx   <= w_q_next;
            end
            if (w_xfer && w_out_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              if (!loop_en) begin
                if (FLUSH_LEN > 0) begin
                  r_state  <= S_FLUSH;
                  m_sample <= '0;
                  r_fcnt   <= '0;
                end else begin
                  r_state <= S_IDLE;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end
              end
            end
          end
          S_FLUSH: begin
            if (w_xfer) begin
              if (r_fcnt == c_flush_last) begin
                r_state <= S_IDLE;
                m_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_fcnt <= r_fcnt + c_fcnt_one;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_source.sv
`default_nettype none
// Scoreboard bench for fir_sample_source: directed frames, expected samples
// queued by the stimulus and popped by a negedge monitor on each transfer.
module tb_fir_sample_source;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int FLUSH_LEN = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W:0]   frame_len = '0;
  logic              start = 1'b0;
  logic              loop_en = 1'b0;
  logic              abort = 1'b0;
  logic              m_valid;
  logic [DATA_W-1:0] m_sample;
  logic              m_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       frame_cnt;

  int              checks = 0;
  int              errors = 0;
  logic [15:0]     sb[$];
  logic            rand_rdy = 1'b0;
  logic            prev_stall = 1'b0;
  logic [15:0]     prev_sample = '0;

  fir_sample_source #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_len(frame_len), .start(start), .loop_en(loop_en), .abort(abort),
    .m_valid(m_valid), .m_sample(m_sample), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_addr = ADDR_W'(a);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic go(input int len);
    frame_len = (ADDR_W+1)'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d, input int n);
    logic [15:0] v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < n; i++) sb.push_back(v[i]);
    for (int i = 0; i < FLUSH_LEN; i++) sb.push_back(16'h0000);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    check("sb_drained", sb.size(), 0);
    check("idle_after_done", busy, 0);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&&ready now.
  always @(negedge clk) begin
    if (rst && !abort) begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_sample", m_sample, prev_sample);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none at %0t", m_sample, $time);
        end else begin
          check("sample", m_sample, sb.pop_front());
        end
      end
    end
    prev_stall  = rst && !abort && m_valid && !m_ready;
    prev_sample = m_sample;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    check("rst_valid", m_valid, 0);
    check("rst_sample", m_sample, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b1;
    tick();

    // 1: basic frame with flush, m_ready held high
    m_ready = 1'b1;
    wr(0, 16'h0001); wr(1, 16'h7FFF); wr(2, 16'h8000); wr(3, 16'hFFFF);
    push_frame(16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 4);
    go(4);
    check("t1_busy", busy, 1);
    check("t1_no_err", err, 0);
    check("t1_valid_T", m_valid, 0);
    tick();
    check("t1_valid_T1", m_valid, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      check("t1_gapless", m_valid, 1);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_valid_end", m_valid, 0);
    check("t1_cnt", frame_cnt, 1);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: same frame under random backpressure
    push_frame(16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 4);
    rand_rdy = 1'b1;
    go(4);
    wait_done(200);
    rand_rdy = 1'b0;
    m_ready  = 1'b1;
    check("t2_cnt", frame_cnt, 2);
    tick();

    // 3: looped frame, loop_en dropped during third pass
    wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(16'h1111); sb.push_back(16'h2222); sb.push_back(16'h3333);
    end
    for (int i = 0; i < FLUSH_LEN; i++) sb.push_back(16'h0000);
    loop_en = 1'b1;
    go(3);
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      check("t3_gapless", m_valid, 1);
      if (i == 2) check("t3_cnt0", frame_cnt, 2);
      if (i == 3) check("t3_cnt1", frame_cnt, 3);
      if (i == 6) check("t3_cnt2", frame_cnt, 4);
      if (i == 7) loop_en = 1'b0;
      tick();
    end
    check("t3_done", done, 1);
    check("t3_cnt3", frame_cnt, 5);
    check("t3_sb", sb.size(), 0);
    tick();

    // 4: abort on the second transfer cycle, then restart
    sb.push_back(16'h1111);
    go(4);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid", m_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    tick();
    check("t4_done_later", done, 0);
    check("t4_cnt", frame_cnt, 5);
    check("t4_sb", sb.size(), 0);
    push_frame(16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 4);
    go(4);
    wait_done(50);
    check("t4_cnt_restart", frame_cnt, 6);
    tick();

    // 5: rejected lengths, then start/write while busy are ignored
    go(0);
    check("t5_err_len0", err, 1);
    check("t5_busy_len0", busy, 0);
    tick();
    check("t5_err_clear", err, 0);
    go(DEPTH + 1);
    check("t5_err_big", err, 1);
    check("t5_busy_big", busy, 0);
    tick();
    push_frame(16'h1111, 16'h2222, 16'h3333, 16'h0000, 3);
    m_ready = 1'b0;
    go(3);
    tick();
    tick();
    tick();
    check("t5_busy", busy, 1);
    wr(0, 16'hDEAD);
    go(2);
    check("t5_no_err_busy", err, 0);
    m_ready = 1'b1;
    wait_done(50);
    check("t5_cnt", frame_cnt, 7);
    tick();
    push_frame(16'h1111, 16'h0000, 16'h0000, 16'h0000, 1);
    go(1);
    wait_done(50);
    check("t5_cnt_old", frame_cnt, 8);
    tick();

    // 6: asynchronous reset mid-flush, then replay intact RAM
    push_frame(16'h1111, 16'h0000, 16'h0000, 16'h0000, 1);
    go(1);
    tick();
    tick();
    tick();
    tick();
    check("t6_busy_flush", busy, 1);
    check("t6_valid_flush", m_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", m_valid, 0);
    check("t6_async_sample", m_sample, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_cnt", frame_cnt, 0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    push_frame(16'h1111, 16'h2222, 16'h3333, 16'h0000, 3);
    go(3);
    wait_done(50);
    check("t6_cnt", frame_cnt, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
